// File: rtl/hazard_d_pkg.sv
// =====================================================================
// hazard_d_pkg : shared opcode/funct codes, Tuse and forward encodings
// Rev 1.0
// =====================================================================
`default_nettype none

package hazard_d_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBGET = 6'b100000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam int             TUSE_W    = 2;
  localparam logic [TUSE_W-1:0] TUSE_NONE = 2'd3;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwd_sel_e;

  // Youngest matching stage wins; an unready youngest match falls back to
  // the register value because that value is not consumed before refresh.
  function automatic fwd_sel_e fwd_pick(input logic hit_e, input logic rdy_e,
                                        input logic hit_m, input logic rdy_m,
                                        input logic hit_w, input logic rdy_w);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (hit_e)      sel = rdy_e ? FWD_E : FWD_RF;
    else if (hit_m) sel = rdy_m ? FWD_M : FWD_RF;
    else if (hit_w) sel = rdy_w ? FWD_W : FWD_RF;
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_d_decode.sv
// =====================================================================
// hazard_decode : instruction -> {dst, Tnew, Tuse_rs, Tuse_rt}
// Rev 1.0
// =====================================================================
`default_nettype none

module hazard_decode
  import hazard_d_pkg::*;
#(
  parameter int TNEW_W = 2,
  parameter int REG_W  = 5
) (
  input  logic [31:0]       instr,
  output logic [REG_W-1:0]  dst,
  output logic [TNEW_W-1:0] tnew,
  output logic [TUSE_W-1:0] tuse_rs,
  output logic [TUSE_W-1:0] tuse_rt
);

  logic [5:0]       op;
  logic [5:0]       fn;
  logic [REG_W-1:0] rt_f;
  logic [REG_W-1:0] rd_f;
  logic             unused_bits;

  assign op   = instr[31:26];
  assign fn   = instr[5:0];
  assign rt_f = REG_W'(instr[20:16]);
  assign rd_f = REG_W'(instr[15:11]);
  assign unused_bits = ^{instr[25:21], instr[10:6]};

  always_comb begin
    dst     = '0;
    tnew    = '0;
    tuse_rs = TUSE_NONE;
    tuse_rt = TUSE_NONE;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB: begin
            dst     = rd_f;
            tnew    = TNEW_W'(1);
            tuse_rs = 2'd1;
            tuse_rt = 2'd1;
          end
          FN_JR:   tuse_rs = 2'd0;
          default: ;
        endcase
      end
      OP_ORI: begin
        dst     = rt_f;
        tnew    = TNEW_W'(1);
        tuse_rs = 2'd1;
      end
      OP_LUI: begin
        dst  = rt_f;
        tnew = TNEW_W'(1);
      end
      OP_LW, OP_LBGET: begin
        dst     = rt_f;
        tnew    = TNEW_W'(2);
        tuse_rs = 2'd1;
      end
      OP_JAL:  dst = REG_W'(31);
      OP_SW: begin
        tuse_rs = 2'd1;
        tuse_rt = 2'd2;
      end
      OP_BEQ: begin
        tuse_rs = 2'd0;
        tuse_rt = 2'd0;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/hazard_d.sv
// =====================================================================
// hazard_d : D-stage stall and D/E/M forwarding-select generator
// Rev 1.0
// =====================================================================
`default_nettype none

module hazard_d
  import hazard_d_pkg::*;
#(
  parameter int TNEW_W = 2,
  parameter int REG_W  = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr_d,
  output logic        stall,
  output logic [1:0]  fwd_rs_d,
  output logic [1:0]  fwd_rt_d,
  output logic [1:0]  fwd_rs_e,
  output logic [1:0]  fwd_rt_e,
  output logic        fwd_rt_m
);

  logic [REG_W-1:0]  dec_dst;
  logic [TNEW_W-1:0] dec_tnew;
  logic [TUSE_W-1:0] dec_tuse_rs;
  logic [TUSE_W-1:0] dec_tuse_rt;
  logic [REG_W-1:0]  src_rs;
  logic [REG_W-1:0]  src_rt;

  logic [REG_W-1:0]  e_dst_q,  e_dst_d;
  logic [TNEW_W-1:0] e_tnew_q, e_tnew_d;
  logic [REG_W-1:0]  e_rs_q,   e_rs_d;
  logic [REG_W-1:0]  e_rt_q,   e_rt_d;
  logic [REG_W-1:0]  m_dst_q,  m_dst_d;
  logic [TNEW_W-1:0] m_tnew_q, m_tnew_d;
  logic [REG_W-1:0]  m_rt_q,   m_rt_d;
  logic [REG_W-1:0]  w_dst_q,  w_dst_d;
  logic [TNEW_W-1:0] w_tnew_q, w_tnew_d;

  logic rdy_e, rdy_m, rdy_w;

  assign src_rs = REG_W'(instr_d[25:21]);
  assign src_rt = REG_W'(instr_d[20:16]);

  hazard_decode #(
    .TNEW_W (TNEW_W),
    .REG_W  (REG_W)
  ) u_decode (
    .instr   (instr_d),
    .dst     (dec_dst),
    .tnew    (dec_tnew),
    .tuse_rs (dec_tuse_rs),
    .tuse_rt (dec_tuse_rt)
  );

  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

  // Register 0 is hard-wired, so it never aliases a producer.
  function automatic logic hit(input logic [REG_W-1:0] dst,
                               input logic [REG_W-1:0] src);
    return (src != '0) && (dst == src);
  endfunction

  function automatic logic too_young(input logic [REG_W-1:0]  dst,
                                     input logic [TNEW_W-1:0] tnew,
                                     input logic [REG_W-1:0]  src,
                                     input logic [TUSE_W-1:0] tuse);
    return (tuse != TUSE_NONE) && hit(dst, src) && (32'(tnew) > 32'(tuse));
  endfunction

  assign rdy_e = (e_tnew_q == '0);
  assign rdy_m = (m_tnew_q == '0);
  assign rdy_w = (w_tnew_q == '0);

  // W always holds a finished result by the time its consumer needs it.
  assign stall = too_young(e_dst_q, e_tnew_q, src_rs, dec_tuse_rs)
               | too_young(m_dst_q, m_tnew_q, src_rs, dec_tuse_rs)
               | too_young(e_dst_q, e_tnew_q, src_rt, dec_tuse_rt)
               | too_young(m_dst_q, m_tnew_q, src_rt, dec_tuse_rt);

  assign fwd_rs_d = fwd_pick(hit(e_dst_q, src_rs), rdy_e,
                             hit(m_dst_q, src_rs), rdy_m,
                             hit(w_dst_q, src_rs), rdy_w);
  assign fwd_rt_d = fwd_pick(hit(e_dst_q, src_rt), rdy_e,
                             hit(m_dst_q, src_rt), rdy_m,
                             hit(w_dst_q, src_rt), rdy_w);
  assign fwd_rs_e = fwd_pick(1'b0, 1'b0,
                             hit(m_dst_q, e_rs_q), rdy_m,
                             hit(w_dst_q, e_rs_q), rdy_w);
  assign fwd_rt_e = fwd_pick(1'b0, 1'b0,
                             hit(m_dst_q, e_rt_q), rdy_m,
                             hit(w_dst_q, e_rt_q), rdy_w);
  assign fwd_rt_m = hit(w_dst_q, m_rt_q);

  always_comb begin
    w_dst_d  = m_dst_q;
    w_tnew_d = sat_dec(m_tnew_q);
    m_dst_d  = e_dst_q;
    m_tnew_d = sat_dec(e_tnew_q);
    m_rt_d   = e_rt_q;
    e_dst_d  = '0;
    e_tnew_d = '0;
    e_rs_d   = '0;
    e_rt_d   = '0;
    if (!stall) begin
      e_dst_d  = dec_dst;
      e_tnew_d = dec_tnew;
      e_rs_d   = src_rs;
      e_rt_d   = src_rt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_dst_q  <= '0;
      e_tnew_q <= '0;
      e_rs_q   <= '0;
      e_rt_q   <= '0;
      m_dst_q  <= '0;
      m_tnew_q <= '0;
      m_rt_q   <= '0;
      w_dst_q  <= '0;
      w_tnew_q <= '0;
    end else begin
      e_dst_q  <= e_dst_d;
      e_tnew_q <= e_tnew_d;
      e_rs_q   <= e_rs_d;
      e_rt_q   <= e_rt_d;
      m_dst_q  <= m_dst_d;
      m_tnew_q <= m_tnew_d;
      m_rt_q   <= m_rt_d;
      w_dst_q  <= w_dst_d;
      w_tnew_q <= w_tnew_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_d.sv
// =====================================================================
// tb_hazard_d : directed and random checks of hazard_d vs. a stage-age model
// Rev 1.0
// =====================================================================
`default_nettype none

module tb_hazard_d;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] instr_d = 32'd0;
  logic        stall;
  logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic        fwd_rt_m;

  always #5 clk = ~clk;

  hazard_d dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .instr_d  (instr_d),
    .stall    (stall),
    .fwd_rs_d (fwd_rs_d),
    .fwd_rt_d (fwd_rt_d),
    .fwd_rs_e (fwd_rs_e),
    .fwd_rt_e (fwd_rt_e),
    .fwd_rt_m (fwd_rt_m)
  );

  localparam int K_ADD = 0, K_SUB = 1, K_ORI = 2, K_LUI = 3, K_LW = 4, K_LBGET = 5;
  localparam int K_JAL = 6, K_SW = 7, K_BEQ = 8, K_J = 9, K_JR = 10, K_UNK = 11;

  // Each entry is an instruction that entered E; slot index = cycles since entry.
  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
  } ent_t;

  ent_t pipe [3];
  int   total = 0;
  int   bad = 0;
  int   cur_kind = K_J;
  logic exp_stall = 1'b0;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void spec_of(input int k, input logic [31:0] ins,
                                  output logic [4:0] dst, output int t,
                                  output int urs, output int urt);
    dst = 5'd0; t = 0; urs = 3; urt = 3;
    case (k)
      K_ADD, K_SUB:  begin dst = ins[15:11]; t = 1; urs = 1; urt = 1; end
      K_ORI:         begin dst = ins[20:16]; t = 1; urs = 1; end
      K_LUI:         begin dst = ins[20:16]; t = 1; end
      K_LW, K_LBGET: begin dst = ins[20:16]; t = 2; urs = 1; end
      K_JAL:         dst = 5'd31;
      K_SW:          begin urs = 1; urt = 2; end
      K_BEQ:         begin urs = 0; urt = 0; end
      K_JR:          urs = 0;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] mk(input int k, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd);
    logic [15:0] imm;
    logic [25:0] tgt;
    imm = 16'($urandom);
    tgt = 26'($urandom);
    case (k)
      K_ADD:   return {6'b000000, rs, rt, rd, 5'd0, 6'b100000};
      K_SUB:   return {6'b000000, rs, rt, rd, 5'd0, 6'b100010};
      K_ORI:   return {6'b001101, rs, rt, imm};
      K_LUI:   return {6'b001111, rs, rt, imm};
      K_LW:    return {6'b100011, rs, rt, imm};
      K_LBGET: return {6'b100000, rs, rt, imm};
      K_SW:    return {6'b101011, rs, rt, imm};
      K_BEQ:   return {6'b000100, rs, rt, imm};
      K_JAL:   return {6'b000011, tgt};
      K_J:     return {6'b000010, tgt};
      K_JR:    return {6'b000000, rs, 5'd0, 5'd0, 5'd0, 6'b001000};
      default: return {6'b111111, rs, rt, imm};
    endcase
  endfunction

  // Remaining cycles until the value in slot i is produced.
  function automatic int eff(input int i);
    int t;
    t = int'(pipe[i].tnew);
    return (t > i) ? t - i : 0;
  endfunction

  function automatic logic stall_for(input logic [4:0] r, input int u);
    if (u == 3 || r == 5'd0) return 1'b0;
    for (int s = 0; s < 2; s++)
      if (pipe[s].dst == r && eff(s) > u) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] fwd_exp(input logic [4:0] r, input int first);
    if (r == 5'd0) return 2'd0;
    for (int s = first; s < 3; s++)
      if (pipe[s].dst == r) return (eff(s) == 0) ? 2'(s + 1) : 2'd0;
    return 2'd0;
  endfunction

  function automatic logic [4:0] rr();
    case ($urandom_range(0, 4))
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd2;
      3: return 5'd3;
      default: return 5'd31;
    endcase
  endfunction

  task automatic go(input int k, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    instr_d  = mk(k, rs, rt, rd);
    cur_kind = k;
  endtask

  task automatic check_cycle();
    logic [4:0] d;
    int t, urs, urt;
    @(negedge clk);
    spec_of(cur_kind, instr_d, d, t, urs, urt);
    exp_stall = stall_for(instr_d[25:21], urs) | stall_for(instr_d[20:16], urt);
    chk("stall", {1'b0, stall}, {1'b0, exp_stall});
    chk("fwd_rs_d", fwd_rs_d, fwd_exp(instr_d[25:21], 0));
    chk("fwd_rt_d", fwd_rt_d, fwd_exp(instr_d[20:16], 0));
    chk("fwd_rs_e", fwd_rs_e, fwd_exp(pipe[0].rs, 1));
    chk("fwd_rt_e", fwd_rt_e, fwd_exp(pipe[0].rt, 1));
    chk("fwd_rt_m", {1'b0, fwd_rt_m},
        {1'b0, (pipe[1].rt != 5'd0) && (pipe[2].dst == pipe[1].rt)});
  endtask

  task automatic adv();
    logic [4:0] d;
    int t, urs, urt;
    ent_t nxt;
    spec_of(cur_kind, instr_d, d, t, urs, urt);
    nxt = exp_stall ? '0 : {d, 2'(t), instr_d[25:21], instr_d[20:16]};
    @(posedge clk);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = nxt;
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    exp_stall = 1'b0;
  endtask

  initial begin
    clear_model();
    go(K_ADD, 5'd1, 5'd1, 5'd2);
    @(negedge clk);
    chk("rst_stall", {1'b0, stall}, 2'd0);
    chk("rst_fwd_rs_d", fwd_rs_d, 2'd0);
    chk("rst_fwd_rs_e", fwd_rs_e, 2'd0);
    chk("rst_fwd_rt_m", {1'b0, fwd_rt_m}, 2'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    check_cycle(); adv();

    // Load-use: one bubble, then W forwarding into E
    go(K_LW, 5'd0, 5'd1, 5'd0);  check_cycle(); adv();
    go(K_ADD, 5'd1, 5'd3, 5'd2); check_cycle(); chk("t1_stall", {1'b0, stall}, 2'd1); adv();
    check_cycle(); chk("t1_release", {1'b0, stall}, 2'd0); adv();
    go(K_J, 5'd0, 5'd0, 5'd0);   check_cycle(); chk("t1_fwd_rs_e", fwd_rs_e, 2'd3); adv();

    // Load then branch: two bubbles, then W to D
    go(K_LW, 5'd0, 5'd1, 5'd0);  check_cycle(); adv();
    go(K_BEQ, 5'd1, 5'd0, 5'd0); check_cycle(); chk("t2_stall_a", {1'b0, stall}, 2'd1); adv();
    check_cycle(); chk("t2_stall_b", {1'b0, stall}, 2'd1); adv();
    check_cycle(); chk("t2_stall_c", {1'b0, stall}, 2'd0); chk("t2_fwd_rs_d", fwd_rs_d, 2'd3); adv();

    // Link register forwarding
    go(K_JAL, 5'd0, 5'd0, 5'd0); check_cycle(); adv();
    go(K_JR, 5'd31, 5'd0, 5'd0); check_cycle();
    chk("t3_stall", {1'b0, stall}, 2'd0); chk("t3_fwd_rs_d", fwd_rs_d, 2'd1); adv();

    // Register 0 never forwards
    go(K_ORI, 5'd0, 5'd0, 5'd0); check_cycle(); adv();
    go(K_ADD, 5'd0, 5'd0, 5'd2); check_cycle();
    chk("t4_stall", {1'b0, stall}, 2'd0);
    chk("t4_fwd_rs_d", fwd_rs_d, 2'd0);
    chk("t4_fwd_rt_d", fwd_rt_d, 2'd0); adv();

    // Store-data chain
    go(K_ADD, 5'd2, 5'd3, 5'd1); check_cycle(); adv();
    go(K_ORI, 5'd0, 5'd1, 5'd0); check_cycle(); adv();
    go(K_SW, 5'd0, 5'd1, 5'd0);  check_cycle();
    chk("t5_stall", {1'b0, stall}, 2'd0); chk("t5_fwd_rt_d", fwd_rt_d, 2'd0); adv();
    go(K_LW, 5'd0, 5'd1, 5'd0);  check_cycle(); chk("t5_fwd_rt_e", fwd_rt_e, 2'd2); adv();
    go(K_J, 5'd0, 5'd0, 5'd0);   check_cycle(); chk("t5_fwd_rt_m", {1'b0, fwd_rt_m}, 2'd1); adv();

    // Asynchronous reset while stalled
    go(K_LW, 5'd0, 5'd1, 5'd0);  check_cycle(); adv();
    go(K_ADD, 5'd1, 5'd3, 5'd2); check_cycle(); chk("t6_pre_stall", {1'b0, stall}, 2'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_stall", {1'b0, stall}, 2'd0);
    chk("t6_rst_fwd_rs_d", fwd_rs_d, 2'd0);
    chk("t6_rst_fwd_rs_e", fwd_rs_e, 2'd0);
    chk("t6_rst_fwd_rt_e", fwd_rt_e, 2'd0);
    chk("t6_rst_fwd_rt_m", {1'b0, fwd_rt_m}, 2'd0);
    clear_model();
    @(posedge clk);
    #1 reset_n = 1'b1;
    check_cycle(); chk("t6_post_stall", {1'b0, stall}, 2'd0); adv();

    // Random instruction stream; a stalled instruction stays in D
    for (int n = 0; n < 400; n++) begin
      if (!exp_stall) go($urandom_range(0, 11), rr(), rr(), rr());
      check_cycle();
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
